misr_sig_checker: RTL



---
 rtl/eqed_sig_pkg.sv | 32 +++
 rtl/misr_core.sv | 49 ++++
 rtl/misr_sig_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/eqed_sig_pkg.sv
// Shared types and defaults for the E-QED MISR signature checker.
package eqed_sig_pkg;

    localparam int unsigned DEF_WIDTH = 6;
    localparam int unsigned DEF_IN_W  = 3;
    localparam int unsigned DEF_CNT_W = 8;

    // Feedback from bits 4 and 5 of the default 6-bit signature
    localparam logic [DEF_WIDTH-1:0] DEF_TAPS = 6'b110000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One compression step for the default geometry: shift left, parity
    // feedback into bit 0, din[k] folded into bit 2k.
    function automatic logic [DEF_WIDTH-1:0] misr_next(
        input logic [DEF_WIDTH-1:0] s,
        input logic [DEF_IN_W-1:0]  din,
        input logic [DEF_WIDTH-1:0] taps
    );
        logic [DEF_WIDTH-1:0] n;
        n = {s[DEF_WIDTH-2:0], ^(s & taps)};
        for (int k = 0; k < int'(DEF_IN_W); k++) begin
            n[2*k] = n[2*k] ^ din[k];
        end
        return n;
    endfunction

endpackage

// File: rtl/misr_core.sv
// Registered multiple-input signature register with seed load.
// WIDTH must be at least 2*IN_W-1 so every injected bit lands inside sig.
module misr_core
    import eqed_sig_pkg::*;
#(
    parameter int unsigned      WIDTH = DEF_WIDTH,
    parameter int unsigned      IN_W  = DEF_IN_W,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic [IN_W-1:0]  din,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_next
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] inject;

    // Spread din onto the even signature bits
    always_comb begin
        inject = '0;
        for (int k = 0; k < int'(IN_W); k++) begin
            inject[2*k] = din[k];
        end
    end

    // Next signature: shift with parity feedback, then fold in the beat
    always_comb begin
        sig_next = {sig_q[WIDTH-2:0], ^(sig_q & TAPS)} ^ inject;
    end

    // Signature register; a seed load wins over compression
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= '0;
        end else if (load) begin
            sig_q <= seed;
        end else if (en) begin
            sig_q <= sig_next;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/misr_sig_checker.sv
// Run controller around misr_core: compresses run_len valid beats, then
// compares the signature against the expected value latched at start.
module misr_sig_checker
    import eqed_sig_pkg::*;
#(
    parameter int unsigned      WIDTH = DEF_WIDTH,
    parameter int unsigned      IN_W  = DEF_IN_W,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter int unsigned      CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] run_len,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] exp_sig,
    input  logic             din_valid,
    input  logic [IN_W-1:0]  din,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] sig,
    output logic [CNT_W-1:0] beats
);

    localparam logic [CNT_W-1:0] BEATS_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic [WIDTH-1:0] exp_sig_q, exp_sig_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic [CNT_W-1:0] beats_inc;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             load;
    logic             en;
    logic [WIDTH-1:0] sig_next;

    misr_core #(
        .WIDTH (WIDTH),
        .IN_W  (IN_W),
        .TAPS  (TAPS)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .seed     (seed),
        .en       (en),
        .din      (din),
        .sig      (sig),
        .sig_next (sig_next)
    );

    // Saturating beat increment
    always_comb begin
        beats_inc = (beats_q == BEATS_MAX) ? beats_q : beats_q + CNT_W'(1);
    end

    // Next-state and control decode; abort overrides everything
    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        exp_sig_d = exp_sig_q;
        beats_d   = beats_q;
        pass_d    = pass_q;
        load      = 1'b0;
        en        = 1'b0;

        if (abort) begin
            state_d = IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        load      = 1'b1;
                        run_len_d = run_len;
                        exp_sig_d = exp_sig;
                        beats_d   = '0;
                        if (run_len != '0) begin
                            state_d = RUN;
                            pass_d  = 1'b0;
                        end else begin
                            state_d = DONE;
                            pass_d  = (seed == exp_sig);
                        end
                    end
                end
                RUN: begin
                    if (din_valid) begin
                        en      = 1'b1;
                        beats_d = beats_inc;
                        // Compare against the next signature so the verdict
                        // lands on the same edge as the final beat
                        if (beats_inc == run_len_q) begin
                            state_d = DONE;
                            pass_d  = (sig_next == exp_sig_q);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            run_len_q <= '0;
            exp_sig_q <= '0;
            beats_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            exp_sig_q <= exp_sig_d;
            beats_q   <= beats_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign pass  = pass_q;
    assign beats = beats_q;

endmodule
